parity_lane_checker: RTL and testbench

Registered, per-lane parity generator/checker for streaming data paths. Each input beat is split into byte-sized (parametrisable) lanes. Per lane, the block either generates a parity bit (generate mode) or compares it against a received parity bit (check mode). Results leave through a one-stage valid/ready register slice. It sits at link and memory-interface boundaries; it keeps sticky per-lane error flags and an optional saturating error-beat counter for status registers.

---
 rtl/parity_lane_checker_if.sv | 29 ++
 rtl/parity_lane_checker.sv | 115 +++++++++++
 tb/tb_parity_lane_checker.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/parity_lane_checker_if.sv
// Beat stream bundle for parity_lane_checker: input beat with its mode and received
// parity, and the registered output beat with its computed parity and error flags.
interface parity_lane_checker_if #(
   parameter int DATA_WIDTH = 32,
   parameter int LANE_WIDTH = 8
);
   localparam int LANES = DATA_WIDTH / LANE_WIDTH;

   logic                  mode;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic [LANES-1:0]      in_parity;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [LANES-1:0]      out_parity;
   logic [LANES-1:0]      out_err;

   modport master (
      output mode, in_valid, in_data, in_parity, out_ready,
      input  in_ready, out_valid, out_data, out_parity, out_err
   );

   modport slave (
      input  mode, in_valid, in_data, in_parity, out_ready,
      output in_ready, out_valid, out_data, out_parity, out_err
   );
endinterface

// File: rtl/parity_lane_checker.sv
// Per-lane parity generator/checker behind a one-stage valid/ready slice, with sticky
// error flags. Define PARITY_ERR_CNT_EN to add the saturating err_count port and counter.
module parity_lane_checker #(
   parameter int DATA_WIDTH  = 32,
   parameter int LANE_WIDTH  = 8,
   parameter int PARITY_TYPE = 0,
   parameter int CNT_WIDTH   = 16,
   localparam int LANES      = DATA_WIDTH / LANE_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   parity_lane_checker_if.slave  bus,
   input  logic                  err_clr,
   output logic [LANES-1:0]      err_sticky
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  err_count
`endif
);

   localparam logic ODD = (PARITY_TYPE != 0);

   if (((DATA_WIDTH % LANE_WIDTH) != 0) || (CNT_WIDTH < 1)) begin : g_bad_cfg
      $error("parity_lane_checker: DATA_WIDTH must be a multiple of LANE_WIDTH and CNT_WIDTH >= 1");
   end

   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic [LANES-1:0]      out_parity_q, out_parity_d;
   logic [LANES-1:0]      out_err_q,   out_err_d;
   logic [LANES-1:0]      err_sticky_q, err_sticky_d;
   logic [LANES-1:0]      lane_par;
   logic [LANES-1:0]      lane_err;
   logic                  accept;

   // Ready passes out_ready straight through so a full slice can drain and refill in one cycle.
   assign bus.in_ready = ~out_valid_q | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;

   always_comb begin
      lane_par = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_par[k] = (^bus.in_data[k*LANE_WIDTH +: LANE_WIDTH]) ^ ODD;
      end
      lane_err = {LANES{bus.mode}} & (lane_par ^ bus.in_parity);
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_parity_d = out_parity_q;
      out_err_d    = out_err_q;
      if (accept) begin
         out_valid_d  = 1'b1;
         out_data_d   = bus.in_data;
         out_parity_d = lane_par;
         out_err_d    = lane_err;
      end else if (bus.out_ready) begin
         out_valid_d  = 1'b0;
      end
   end

   // A clear coinciding with an erroneous accept keeps only the new beat's errors.
   always_comb begin
      err_sticky_d = err_clr ? '0 : err_sticky_q;
      if (accept) begin
         err_sticky_d = err_sticky_d | lane_err;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_parity_q <= '0;
         out_err_q    <= '0;
         err_sticky_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_parity_q <= out_parity_d;
         out_err_q    <= out_err_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_parity = out_parity_q;
   assign bus.out_err    = out_err_q;
   assign err_sticky     = err_sticky_q;

`ifdef PARITY_ERR_CNT_EN
   logic [CNT_WIDTH-1:0] err_count_q, err_count_d, cnt_base;

   always_comb begin
      cnt_base    = err_clr ? '0 : err_count_q;
      err_count_d = cnt_base;
      if (accept && (|lane_err) && (cnt_base != {CNT_WIDTH{1'b1}})) begin
         err_count_d = cnt_base + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_parity_lane_checker.sv
// Bench for parity_lane_checker: an even-parity/16-bit-count instance and an
// odd-parity/2-bit-count instance share one stimulus stream and one reference model.
module tb_parity_lane_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mode = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_parity = '0;
   logic        out_ready = 1'b0;
   logic        err_clr = 1'b0;

   logic [3:0]  sticky_e, sticky_o;
   logic [15:0] count_e;
   logic [1:0]  count_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   parity_lane_checker_if #(.DATA_WIDTH(32), .LANE_WIDTH(8)) bus_e ();
   parity_lane_checker_if #(.DATA_WIDTH(32), .LANE_WIDTH(8)) bus_o ();

   assign bus_e.mode = mode;      assign bus_o.mode = mode;
   assign bus_e.in_valid = in_valid;  assign bus_o.in_valid = in_valid;
   assign bus_e.in_data = in_data;    assign bus_o.in_data = in_data;
   assign bus_e.in_parity = in_parity; assign bus_o.in_parity = in_parity;
   assign bus_e.out_ready = out_ready; assign bus_o.out_ready = out_ready;

   parity_lane_checker #(.DATA_WIDTH(32), .LANE_WIDTH(8), .PARITY_TYPE(0), .CNT_WIDTH(16)) dut_e (
      .clk(clk), .rst_n(rst_n), .bus(bus_e.slave), .err_clr(err_clr), .err_sticky(sticky_e)
`ifdef PARITY_ERR_CNT_EN
      , .err_count(count_e)
`endif
   );

   parity_lane_checker #(.DATA_WIDTH(32), .LANE_WIDTH(8), .PARITY_TYPE(1), .CNT_WIDTH(2)) dut_o (
      .clk(clk), .rst_n(rst_n), .bus(bus_o.slave), .err_clr(err_clr), .err_sticky(sticky_o)
`ifdef PARITY_ERR_CNT_EN
      , .err_count(count_o)
`endif
   );

`ifndef PARITY_ERR_CNT_EN
   assign count_e = '0;
   assign count_o = '0;
`endif

   // Reference model: queue of accepted beats (raw inputs), per-instance sticky/count.
   typedef struct {
      logic [31:0] d;
      logic [3:0]  p;
      logic        m;
   } beat_t;

   beat_t       fifo[$];
   logic [3:0]  m_st[2];
   int          m_cnt[2];
   int          m_max[2];

   function automatic logic [3:0] par_model(logic [31:0] d, int odd);
      logic [3:0] p;
      logic [7:0] lane;
      for (int k = 0; k < 4; k++) begin
         lane = d[k*8 +: 8];
         p[k] = (($countones(lane) % 2) == 1) ? 1'b1 : 1'b0;
         if (odd != 0) p[k] = ~p[k];
      end
      return p;
   endfunction

   function automatic logic [3:0] err_model(beat_t b, int odd);
      return b.m ? (par_model(b.d, odd) ^ b.p) : 4'b0000;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(string ph);
      logic       exp_ready;
      logic [3:0] obs_par, obs_err;
      logic [31:0] obs_dat;
      logic       obs_v;
      logic [3:0] obs_st;
      int         obs_cnt;
      exp_ready = (fifo.size() == 0) || out_ready;
      chk({ph, ":ready_e"}, 64'(bus_e.in_ready), 64'(exp_ready));
      chk({ph, ":ready_o"}, 64'(bus_o.in_ready), 64'(exp_ready));
      for (int d = 0; d < 2; d++) begin
         obs_v   = (d == 0) ? bus_e.out_valid  : bus_o.out_valid;
         obs_dat = (d == 0) ? bus_e.out_data   : bus_o.out_data;
         obs_par = (d == 0) ? bus_e.out_parity : bus_o.out_parity;
         obs_err = (d == 0) ? bus_e.out_err    : bus_o.out_err;
         obs_st  = (d == 0) ? sticky_e         : sticky_o;
         obs_cnt = (d == 0) ? int'(count_e)    : int'(count_o);
         chk($sformatf("%s:valid%0d", ph, d), 64'(obs_v), 64'(fifo.size() > 0));
         if (fifo.size() > 0) begin
            chk($sformatf("%s:data%0d", ph, d), 64'(obs_dat), 64'(fifo[0].d));
            chk($sformatf("%s:parity%0d", ph, d), 64'(obs_par), 64'(par_model(fifo[0].d, d)));
            chk($sformatf("%s:err%0d", ph, d), 64'(obs_err), 64'(err_model(fifo[0], d)));
         end
         chk($sformatf("%s:sticky%0d", ph, d), 64'(obs_st), 64'(m_st[d]));
`ifdef PARITY_ERR_CNT_EN
         chk($sformatf("%s:count%0d", ph, d), 64'(obs_cnt), 64'(m_cnt[d]));
`endif
      end
   endtask

   task automatic check_reset(string ph);
      chk({ph, ":ready_e"}, 64'(bus_e.in_ready), 64'(1));
      chk({ph, ":ready_o"}, 64'(bus_o.in_ready), 64'(1));
      chk({ph, ":outs_e"}, {bus_e.out_valid, bus_e.out_data, bus_e.out_parity, bus_e.out_err, sticky_e}, 64'(0));
      chk({ph, ":outs_o"}, {bus_o.out_valid, bus_o.out_data, bus_o.out_parity, bus_o.out_err, sticky_o}, 64'(0));
`ifdef PARITY_ERR_CNT_EN
      chk({ph, ":count_e"}, 64'(count_e), 64'(0));
      chk({ph, ":count_o"}, 64'(count_o), 64'(0));
`endif
   endtask

   task automatic model_reset();
      fifo.delete();
      for (int d = 0; d < 2; d++) begin
         m_st[d]  = '0;
         m_cnt[d] = 0;
      end
   endtask

   // One clock: check state and ready against current inputs, advance the model, take the edge.
   task automatic step(string ph);
      logic  acc, otr;
      beat_t b;
      logic [3:0] e;
      int    base;
      #1;
      check_all(ph);
      acc = in_valid && ((fifo.size() == 0) || out_ready);
      otr = (fifo.size() > 0) && out_ready;
      b.d = in_data; b.p = in_parity; b.m = mode;
      for (int d = 0; d < 2; d++) begin
         if (err_clr) begin
            m_st[d]  = '0;
            m_cnt[d] = 0;
         end
         if (acc) begin
            e = err_model(b, d);
            m_st[d] = m_st[d] | e;
            base = m_cnt[d];
            if (e != 0) m_cnt[d] = (base + 1 > m_max[d]) ? m_max[d] : base + 1;
         end
      end
      if (otr) void'(fifo.pop_front());
      if (acc) fifo.push_back(b);
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic v, logic md, logic [31:0] d, logic [3:0] p, logic rdy, logic clr);
      in_valid = v; mode = md; in_data = d; in_parity = p; out_ready = rdy; err_clr = clr;
   endtask

   initial begin
      m_max[0] = 65535;
      m_max[1] = 3;
      model_reset();

      #2 rst_n = 1'b0;
      #1 check_reset("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Generate mode: even lanes -> 0010, odd instance -> 1101.
      drive(1, 0, 32'h0000_0103, 4'hF, 1, 0); step("gen1");
      drive(1, 0, 32'h0000_0000, 4'h0, 1, 0); step("gen2");
      drive(0, 0, 32'h0, 4'h0, 1, 0);          step("gen3");

      // Check mode: lane 2 fails on the even instance; same beat twice.
      drive(1, 1, 32'hFF01_0000, 4'b0000, 1, 0); step("chk1");
      step("chk2");
      drive(0, 0, 32'h0, 4'h0, 1, 0);            step("chk3");

      // Backpressure: ready low for 3 cycles with continuous valid.
      for (int i = 0; i < 3; i++) begin
         drive(1, $urandom_range(0, 1), $urandom, 4'($urandom), 1, 0); step("bp_fill");
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, $urandom_range(0, 1), $urandom, 4'($urandom), 0, 0); step("bp_hold");
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, $urandom_range(0, 1), $urandom, 4'($urandom), 1, 0); step("bp_rel");
      end

      // Saturation, then clear together with an erroneous accept.
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 32'hFF01_0000, 4'b0000, 1, 0); step("sat");
      end
      drive(1, 1, 32'h0000_00FE, 4'b0000, 1, 1); step("clr_err");
      drive(0, 0, 32'h0, 4'h0, 1, 0);            step("clr_chk");
      drive(0, 0, 32'h0, 4'h0, 1, 1);            step("clr_only");
      drive(0, 0, 32'h0, 4'h0, 1, 0);            step("clr_only_chk");

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom, 4'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         step("rand");
      end

      // Mid-stream reset with a held beat and saturated short counter.
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 32'hFF01_0000, 4'b0000, 1, 0); step("pre_rst");
      end
      drive(1, 1, 32'hFF01_0000, 4'b0000, 0, 0); step("pre_rst_hold");
      #1 check_all("pre_rst_state");
      drive(0, 0, 32'h0, 4'h0, 0, 0);
      rst_n = 1'b0;
      #1 check_reset("mid_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 0, 32'h8000_0001, 4'h0, 1, 0); step("post_rst1");
      drive(0, 0, 32'h0, 4'h0, 1, 0);          step("post_rst2");
      #1 check_all("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
